// File: rtl/hit_judge_ctrl.sv
// hit_judge_ctrl
//   Game sequencer and hit judge that sits in front of the score datapath.
//   Tracks the GAME/PAUSE/RESET game state, judges directional button chords
//   against the arrow currently at the hit line, and queues the results.
//   Each result comes out as a stretched, spaced pulse on correct_hit_o or
//   incorrect_hit_o, which the scorer edge-detects through a shift register.
//
// Ports
//   clk_i            system clock
//   rst_i            synchronous active-high reset
//   pause_req_i      debounced pause level; rising edge toggles GAME/PAUSE
//   reset_req_i      debounced reset level; rising edge forces RESET
//   arrow_valid_i    1-cycle strobe: new arrow at the hit line
//   arrow_code_i     arrow code (10..20), sampled with arrow_valid_i
//   btn_dir_i        debounced button levels {up,down,left,right}
//   state_o          0=GAME 1=PAUSE 2=RESET
//   correct_hit_o    stretched hit pulse
//   incorrect_hit_o  stretched miss pulse
//   window_open_o    judgement window active
//   fifo_ovf_o       sticky result-dropped flag, cleared by RESET
//
// CHORD_CYCLES must be >= 2, PULSE_CYCLES >= 1, GAP_CYCLES >= 1 and
// FIFO_DEPTH a power of two >= 2.

module hit_judge_ctrl #(
    parameter int WINDOW_CYCLES = 16,
    parameter int CHORD_CYCLES  = 4,
    parameter int PULSE_CYCLES  = 2,
    parameter int GAP_CYCLES    = 1,
    parameter int RESET_CYCLES  = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pause_req_i,
    input  logic       reset_req_i,
    input  logic       arrow_valid_i,
    input  logic [4:0] arrow_code_i,
    input  logic [3:0] btn_dir_i,
    output logic [1:0] state_o,
    output logic       correct_hit_o,
    output logic       incorrect_hit_o,
    output logic       window_open_o,
    output logic       fifo_ovf_o
);

    localparam int WT_W   = $clog2(WINDOW_CYCLES + 1);
    localparam int CT_W   = (CHORD_CYCLES > 2) ? $clog2(CHORD_CYCLES) : 1;
    localparam int RC_W   = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;
    localparam int PC_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int PC_W   = (PC_MAX > 2) ? $clog2(PC_MAX) : 1;
    localparam int AW     = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = AW + 1;

    localparam logic [WT_W-1:0]  WIN_INIT   = WT_W'(WINDOW_CYCLES);
    localparam logic [WT_W-1:0]  WIN_LAST   = WT_W'(1);
    localparam logic [CT_W-1:0]  CHORD_INIT = CT_W'(CHORD_CYCLES - 1);
    localparam logic [CT_W-1:0]  CHORD_LAST = CT_W'(1);
    localparam logic [RC_W-1:0]  RST_LAST   = RC_W'(RESET_CYCLES - 1);
    localparam logic [PC_W-1:0]  PULSE_LAST = PC_W'(PULSE_CYCLES - 1);
    localparam logic [PC_W-1:0]  GAP_LAST   = PC_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_GAME  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_RESET = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PG_IDLE = 2'd0,
        PG_HIGH = 2'd1,
        PG_GAP  = 2'd2
    } pg_e;

    // Arrow code to required {U,D,L,R} mask; unknown codes behave as 20.
    function automatic logic [3:0] arrow_mask(input logic [4:0] code);
        logic [3:0] m;
        case (code)
            5'd10:   m = 4'b1000;
            5'd11:   m = 4'b0100;
            5'd12:   m = 4'b0010;
            5'd13:   m = 4'b0001;
            5'd14:   m = 4'b1100;
            5'd15:   m = 4'b1010;
            5'd16:   m = 4'b1001;
            5'd17:   m = 4'b0110;
            5'd18:   m = 4'b0101;
            5'd19:   m = 4'b0011;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Input edge detection. The previous-level registers track the inputs
    // in every state, so a button held through PAUSE produces no edge on
    // resume.
    // ------------------------------------------------------------------
    logic       pause_prev_q, reset_prev_q;
    logic [3:0] btn_prev_q;
    logic       pause_edge, reset_edge, btn_edge;

    assign pause_edge = pause_req_i & ~pause_prev_q;
    assign reset_edge = reset_req_i & ~reset_prev_q;
    assign btn_edge   = |(btn_dir_i & ~btn_prev_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pause_prev_q <= 1'b0;
            reset_prev_q <= 1'b0;
            btn_prev_q   <= 4'b0000;
        end else begin
            pause_prev_q <= pause_req_i;
            reset_prev_q <= reset_req_i;
            btn_prev_q   <= btn_dir_i;
        end
    end

    // ------------------------------------------------------------------
    // Game state machine. A reset request wins over a pause request.
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [RC_W-1:0] rst_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_RESET;
            rst_cnt_q <= '0;
        end else if (reset_edge) begin
            state_q   <= ST_RESET;
            rst_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (rst_cnt_q == RST_LAST) state_q <= ST_GAME;
                    else                       rst_cnt_q <= rst_cnt_q + 1'b1;
                end
                ST_GAME:  if (pause_edge) state_q <= ST_PAUSE;
                ST_PAUSE: if (pause_edge) state_q <= ST_GAME;
                default:  state_q <= ST_RESET;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Judge. Only advances in GAME, which freezes both timers in PAUSE.
    // At most one result is pushed per cycle: a new arrow supersedes any
    // chord in progress, and a running chord masks window expiry so the
    // chord's judgement stands even if it outlives the window.
    // ------------------------------------------------------------------
    logic            win_open_q, win_open_d;
    logic [WT_W-1:0] win_timer_q, win_timer_d;
    logic [3:0]      mask_q, mask_d;
    logic            chord_q, chord_d;
    logic [CT_W-1:0] chord_cnt_q, chord_cnt_d;
    logic [3:0]      pressed_q, pressed_d;
    logic            judged_q, judged_d;   // chord belongs to an open window
    logic            push, push_hit;

    always_comb begin
        win_open_d  = win_open_q;
        win_timer_d = win_timer_q;
        mask_d      = mask_q;
        chord_d     = chord_q;
        chord_cnt_d = chord_cnt_q;
        pressed_d   = pressed_q;
        judged_d    = judged_q;
        push        = 1'b0;
        push_hit    = 1'b0;

        if (reset_edge) begin
            win_open_d = 1'b0;
            chord_d    = 1'b0;
        end else if (state_q == ST_GAME) begin
            if (arrow_valid_i) begin
                // The arrow still waiting for a judgement is a miss.
                push        = win_open_q;
                win_open_d  = 1'b1;
                win_timer_d = WIN_INIT;
                mask_d      = arrow_mask(arrow_code_i);
                chord_d     = 1'b0;
                if (btn_edge) begin
                    chord_d     = 1'b1;
                    chord_cnt_d = CHORD_INIT;
                    pressed_d   = btn_dir_i;
                    judged_d    = 1'b1;
                end
            end else if (chord_q) begin
                pressed_d = pressed_q | btn_dir_i;
                if (chord_cnt_q == CHORD_LAST) begin
                    chord_d = 1'b0;
                    if (judged_q) begin
                        push       = 1'b1;
                        push_hit   = (pressed_d == mask_q);
                        win_open_d = 1'b0;
                    end
                end else begin
                    chord_cnt_d = chord_cnt_q - 1'b1;
                end
            end else if (btn_edge) begin
                // A stray chord reports one miss up front and then just
                // swallows further edges until its timer runs out.
                chord_d     = 1'b1;
                chord_cnt_d = CHORD_INIT;
                pressed_d   = btn_dir_i;
                judged_d    = win_open_q;
                push        = ~win_open_q;
            end else if (win_open_q) begin
                if (win_timer_q == WIN_LAST) begin
                    win_open_d = 1'b0;
                    push       = (mask_q != 4'b0000);
                end else begin
                    win_timer_d = win_timer_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_open_q  <= 1'b0;
            win_timer_q <= '0;
            chord_q     <= 1'b0;
            chord_cnt_q <= '0;
            judged_q    <= 1'b0;
        end else begin
            win_open_q  <= win_open_d;
            win_timer_q <= win_timer_d;
            chord_q     <= chord_d;
            chord_cnt_q <= chord_cnt_d;
            judged_q    <= judged_d;
        end
        mask_q    <= mask_d;
        pressed_q <= pressed_d;
    end

    // ------------------------------------------------------------------
    // Result FIFO and pulse generator. The generator may pop again in the
    // last gap cycle, so pulses come out back to back with exactly
    // GAP_CYCLES low cycles between them. A push into a full FIFO is
    // dropped even if a pop happens in the same cycle.
    // ------------------------------------------------------------------
    logic             mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    pg_e              pg_q, pg_d;
    logic [PC_W-1:0]  pg_cnt_q, pg_cnt_d;
    logic             corr_q, corr_d, inc_q, inc_d;
    logic             pg_ready, pop, push_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        pg_d     = pg_q;
        pg_cnt_d = pg_cnt_q;
        corr_d   = corr_q;
        inc_d    = inc_q;

        pg_ready = (pg_q == PG_IDLE) || ((pg_q == PG_GAP) && (pg_cnt_q == '0));
        pop      = pg_ready && (cnt_q != '0) && !reset_edge;
        push_ok  = push && (cnt_q != CNT_FULL);

        if (reset_edge) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            pg_d     = PG_IDLE;
            pg_cnt_d = '0;
            corr_d   = 1'b0;
            inc_d    = 1'b0;
        end else begin
            if (push && !push_ok) ovf_d = 1'b1;
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase

            if (pop) begin
                corr_d   = mem_q[rd_ptr_q];
                inc_d    = ~mem_q[rd_ptr_q];
                pg_d     = PG_HIGH;
                pg_cnt_d = PULSE_LAST;
            end else begin
                case (pg_q)
                    PG_HIGH: begin
                        if (pg_cnt_q == '0) begin
                            corr_d   = 1'b0;
                            inc_d    = 1'b0;
                            pg_d     = PG_GAP;
                            pg_cnt_d = GAP_LAST;
                        end else begin
                            pg_cnt_d = pg_cnt_q - 1'b1;
                        end
                    end
                    PG_GAP: begin
                        if (pg_cnt_q == '0) pg_d = PG_IDLE;
                        else                pg_cnt_d = pg_cnt_q - 1'b1;
                    end
                    default: pg_d = PG_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            pg_q     <= PG_IDLE;
            pg_cnt_q <= '0;
            corr_q   <= 1'b0;
            inc_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            pg_q     <= pg_d;
            pg_cnt_q <= pg_cnt_d;
            corr_q   <= corr_d;
            inc_q    <= inc_d;
        end
        if (push_ok && !reset_edge) mem_q[wr_ptr_q] <= push_hit;
    end

    assign state_o         = state_q;
    assign correct_hit_o   = corr_q;
    assign incorrect_hit_o = inc_q;
    assign window_open_o   = win_open_q;
    assign fifo_ovf_o      = ovf_q;

endmodule

// File: tb/tb_hit_judge_ctrl.sv
module tb_hit_judge_ctrl;

    localparam int W = 16;  // window cycles
    localparam int C = 4;   // chord cycles
    localparam int P = 2;   // pulse high cycles
    localparam int G = 1;   // pulse gap cycles
    localparam int R = 4;   // reset cycles
    localparam int D = 4;   // fifo depth

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_req = 1'b0;
    logic       reset_req = 1'b0;
    logic       arrow_valid = 1'b0;
    logic [4:0] arrow_code = 5'd0;
    logic [3:0] btn_dir = 4'd0;
    logic [1:0] state;
    logic       correct_hit, incorrect_hit, window_open, fifo_ovf;

    always #5 clk = ~clk;

    hit_judge_ctrl #(
        .WINDOW_CYCLES(W), .CHORD_CYCLES(C), .PULSE_CYCLES(P),
        .GAP_CYCLES(G), .RESET_CYCLES(R), .FIFO_DEPTH(D)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pause_req_i(pause_req), .reset_req_i(reset_req),
        .arrow_valid_i(arrow_valid), .arrow_code_i(arrow_code), .btn_dir_i(btn_dir),
        .state_o(state), .correct_hit_o(correct_hit), .incorrect_hit_o(incorrect_hit),
        .window_open_o(window_open), .fifo_ovf_o(fifo_ovf)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp_v, input int e);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e, act, exp_v);
        end
    endtask

    // Scoreboard entry: result kind and the clock edge its pulse must rise on.
    typedef struct {
        bit hit;
        int pop_edge;
    } res_t;
    res_t exp_q[$];

    bit [3:0] mask_tbl [32];

    // Reference model, kept in absolute edge numbers and "game time"
    // (a count of GAME cycles, which is what the timers measure).
    int       m_state = 2;
    int       m_leave = 0;
    int       gt = 0;
    bit       m_win = 0;
    int       m_deadline = 0;
    bit [3:0] m_mask = 0;
    bit       m_chord = 0;
    int       m_chord_end = 0;
    bit       m_judged = 0;
    bit [3:0] m_pressed = 0;
    bit       m_ovf = 0;
    int       last_pop = -100;
    int       flush_edge = -1;
    bit       p_pause = 0, p_reset = 0;
    bit [3:0] p_btn = 0;
    bit       mon_en = 0;

    function automatic void model_push(input bit hit, input int e);
        int pe;
        if (exp_q.size() >= D) begin
            m_ovf = 1;
        end else begin
            pe = e + 1;
            if (last_pop + P + G > pe) pe = last_pop + P + G;
            last_pop = pe;
            exp_q.push_back('{hit, pe});
        end
    endfunction

    function automatic void model_flush(input int e);
        exp_q.delete();
        last_pop   = -100;
        flush_edge = e;
        m_state    = 2;
        m_leave    = e + R;
        m_win      = 0;
        m_chord    = 0;
        m_ovf      = 0;
    endfunction

    function automatic void start_chord(input bit judged, input int g);
        m_chord     = 1;
        m_chord_end = g + C - 1;
        m_pressed   = btn_dir;
        m_judged    = judged;
    endfunction

    function automatic void model_judge(input int e, input bit press);
        int g = gt;
        if (arrow_valid) begin
            if (m_win) model_push(0, e);
            m_win      = 1;
            m_deadline = g + W;
            m_mask     = mask_tbl[arrow_code];
            m_chord    = 0;
            if (press) start_chord(1, g);
        end else if (m_chord) begin
            m_pressed = m_pressed | btn_dir;
            if (g == m_chord_end) begin
                m_chord = 0;
                if (m_judged) begin
                    model_push(m_pressed == m_mask, e);
                    m_win = 0;
                end
            end
        end else if (press) begin
            if (m_win) start_chord(1, g);
            else begin
                model_push(0, e);
                start_chord(0, g);
            end
        end else if (m_win && g == m_deadline) begin
            m_win = 0;
            if (m_mask != 0) model_push(0, e);
        end
    endfunction

    function automatic void model_step(input int e);
        bit ep, er, eb;
        ep = pause_req & !p_pause;
        er = reset_req & !p_reset;
        eb = |(btn_dir & ~p_btn);
        if (rst) begin
            model_flush(e);
            p_pause = 0; p_reset = 0; p_btn = 0;
            return;
        end
        if (er) model_flush(e);
        else if (m_state == 2) begin
            if (e == m_leave) m_state = 0;
        end else if (m_state == 0) begin
            model_judge(e, eb);
            gt++;
            if (ep) m_state = 1;
        end else if (ep) m_state = 0;
        p_pause = pause_req;
        p_reset = reset_req;
        p_btn   = btn_dir;
    endfunction

    // Monitor: compares every cycle, pops a scoreboard entry when its pulse
    // is due and expects that pulse level for P cycles.
    res_t cur;
    bit   cur_v = 0;
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            int  n;
            bit  ec, ei;
            n = cyc;
            if (flush_edge == n) cur_v = 0;
            if (exp_q.size() > 0 && exp_q[0].pop_edge == n) begin
                cur   = exp_q.pop_front();
                cur_v = 1;
            end
            ec = cur_v && cur.hit  && (n < cur.pop_edge + P);
            ei = cur_v && !cur.hit && (n < cur.pop_edge + P);
            if (cur_v && n >= cur.pop_edge + P - 1) cur_v = 0;
            chk("correct_hit",   int'(correct_hit),   int'(ec), n);
            chk("incorrect_hit", int'(incorrect_hit), int'(ei), n);
            chk("state",         int'(state),         m_state,  n);
            chk("window_open",   int'(window_open),   int'(m_win), n);
            chk("fifo_ovf",      int'(fifo_ovf),      int'(m_ovf), n);
            if (exp_q.size() > 0 && exp_q[0].pop_edge < n) begin
                chk("pulse_schedule", exp_q[0].pop_edge, n, n);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        model_step(cyc + 1);
        mon_en = 1;
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        arrow_valid = 0;
        repeat (k) tick();
    endtask

    task automatic arrow(input int code);
        arrow_valid = 1;
        arrow_code  = 5'(code);
        tick();
        arrow_valid = 0;
    endtask

    task automatic press(input bit [3:0] m, input int k);
        btn_dir = m;
        repeat (k) tick();
    endtask

    int       sched = 0;
    bit [3:0] sched_mask = 0;

    initial begin
        bit [3:0] vals [11];
        vals = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b1010,
                 4'b1001, 4'b0110, 4'b0101, 4'b0011, 4'b0000};
        for (int i = 0; i < 32; i++) mask_tbl[i] = 4'b0000;
        for (int i = 0; i < 11; i++) mask_tbl[i + 10] = vals[i];

        // reset, then RESET for R cycles and GAME afterwards
        rst = 1;
        tick();
        rst = 0;
        idle(8);

        // single arrow, matching press
        arrow(10); idle(2); press(4'b1000, 2); press(4'b0000, 1); idle(12);

        // two-button chord in time, then with the second button too late
        arrow(16); press(4'b1000, 2); press(4'b1001, 2); press(4'b0000, 1); idle(12);
        arrow(16); press(4'b1000, 6); press(4'b1001, 2); press(4'b0000, 1); idle(14);

        // window expiry with a real arrow, then with an empty arrow
        arrow(12); idle(22);
        arrow(20); idle(22);

        // back-to-back superseded arrows overflow the result queue
        repeat (8) arrow(10);
        idle(40);

        // pause mid-window, long hold, press on resume; clears ovf via reset
        reset_req = 1; tick(); reset_req = 0; idle(6);
        arrow(12); idle(4);
        pause_req = 1; tick(); pause_req = 0; idle(50);
        pause_req = 1; tick(); pause_req = 0;
        press(4'b0010, 2); press(4'b0000, 1); idle(12);

        // reset request while a pulse is high
        arrow(10); arrow(10); idle(1);
        reset_req = 1; tick(); reset_req = 0; idle(8);

        // randomized play
        for (int k = 0; k < 3000; k++) begin
            arrow_valid = ($urandom_range(0, 9) == 0);
            arrow_code  = 5'($urandom_range(8, 23));
            if (arrow_valid && $urandom_range(0, 1) == 1) begin
                sched      = $urandom_range(1, 12);
                sched_mask = mask_tbl[arrow_code];
                btn_dir    = 4'b0000;
            end else if (sched > 0) begin
                sched--;
                if (sched == 0) btn_dir = sched_mask;
            end else if ($urandom_range(0, 7) == 0) begin
                btn_dir = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 99) == 0)   pause_req = ~pause_req;
            if ($urandom_range(0, 299) == 0)  reset_req = ~reset_req;
            rst = ($urandom_range(0, 1999) == 0);
            tick();
        end
        rst = 0;
        btn_dir = 4'b0000;
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
